seg7_scan_decoder: RTL and testbench

Loopback monitor for the multiplexed 7-segment display: it reads the scanned anode/cathode lines produced by the display controller and reconstructs the four displayed digits. It filters transient patterns, decodes segment codes back to BCD, and reports complete frames. It sits beside the display controller on the board-level top, uses the same system clock, and feeds self-check logic and the test bench.

---
 rtl/seg7_scan_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Loopback monitor: rebuilds the 4 displayed digits from scanned anode/cathode lines (optional SEG7_SCAN_ERR_EN adds the sticky err flag).
// Latency: a pin pattern stable from edge k is captured on edge k+2+STABLE_CYC; frame_valid pulses on the capture completing a frame.
// Backpressure: none; passive observer, outputs hold between frames.
module seg7_scan_decoder #(
    parameter int N_DIG       = 4,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_DIG-1:0]     anodo,
    input  logic [7:0]           catodo,
    output logic [4*N_DIG-1:0]   frame_data,
    output logic [N_DIG-1:0]     frame_dp,
    output logic                 frame_valid,
    output logic                 scan_active,
    output logic                 err
);

    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int CNT_W = $clog2(STABLE_CYC);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W:0]   ONE_LOW     = {{IDX_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t               state;
    logic [N_DIG-1:0]     an_s1, an_s2;
    logic [7:0]           cat_s1, cat_s2;
    logic [N_DIG+7:0]     pat_prev, pat_now;
    logic                 pat_chg;
    logic [CNT_W-1:0]     stb_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic [N_DIG-1:0]     mask, mask_nxt;
    logic [4*N_DIG-1:0]   stg_dat, stg_dat_nxt;
    logic [N_DIG-1:0]     stg_dp, stg_dp_nxt;
    logic [IDX_W:0]       n_low;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_ok;
    logic [3:0]           dig_code;
    logic                 dig_dp;
    logic                 cap;
    logic                 to_hit;

    assign pat_now = {an_s2, cat_s2};
    assign pat_chg = (pat_now != pat_prev);

    always_comb begin
        n_low   = '0;
        sel_idx = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (!an_s2[i]) begin
                n_low   = n_low + 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
        sel_ok = (n_low == ONE_LOW);
    end

    // Segments are active-low, so decode on the inverted a..g field.
    always_comb begin
        dig_code = 4'hF;
        case (~cat_s2[7:1])
            7'b1111110: dig_code = 4'h0;
            7'b0110000: dig_code = 4'h1;
            7'b1101101: dig_code = 4'h2;
            7'b1111001: dig_code = 4'h3;
            7'b0110011: dig_code = 4'h4;
            7'b1011011: dig_code = 4'h5;
            7'b1011111: dig_code = 4'h6;
            7'b1110000: dig_code = 4'h7;
            7'b1111111: dig_code = 4'h8;
            7'b1111011: dig_code = 4'h9;
            7'b0000000: dig_code = 4'hA;
            default:    dig_code = 4'hF;
        endcase
        dig_dp = ~cat_s2[0];
    end

    assign cap    = (state == SETTLE) && !pat_chg && (stb_cnt == STABLE_LAST);
    assign to_hit = !cap && (to_cnt == TO_LAST);

    always_comb begin
        stg_dat_nxt                  = stg_dat;
        stg_dat_nxt[4*sel_idx +: 4]  = dig_code;
        stg_dp_nxt                   = stg_dp;
        stg_dp_nxt[sel_idx]          = dig_dp;
        mask_nxt                     = mask;
        mask_nxt[sel_idx]            = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_s1       <= '1;
            an_s2       <= '1;
            cat_s1      <= '1;
            cat_s2      <= '1;
            pat_prev    <= '1;
            state       <= IDLE;
            stb_cnt     <= '0;
            mask        <= '0;
            stg_dat     <= {N_DIG{4'hA}};
            stg_dp      <= '0;
            frame_data  <= {N_DIG{4'hA}};
            frame_dp    <= '0;
            frame_valid <= 1'b0;
            scan_active <= 1'b0;
            to_cnt      <= TO_MAX;
        end else begin
            an_s1       <= anodo;
            an_s2       <= an_s1;
            cat_s1      <= catodo;
            cat_s2      <= cat_s1;
            pat_prev    <= pat_now;
            frame_valid <= 1'b0;

            // A timeout abandons any select still settling.
            if (to_hit) begin
                state <= IDLE;
            end else if (pat_chg) begin
                state   <= sel_ok ? SETTLE : IDLE;
                stb_cnt <= '0;
            end else if (state == SETTLE) begin
                if (cap) begin
                    state <= HELD;
                end else begin
                    stb_cnt <= stb_cnt + 1'b1;
                end
            end

            if (cap) begin
                stg_dat     <= stg_dat_nxt;
                stg_dp      <= stg_dp_nxt;
                to_cnt      <= '0;
                scan_active <= 1'b1;
                if (&mask_nxt) begin
                    frame_data  <= stg_dat_nxt;
                    frame_dp    <= stg_dp_nxt;
                    frame_valid <= 1'b1;
                    mask        <= '0;
                end else begin
                    mask <= mask_nxt;
                end
            end else begin
                if (to_cnt != TO_MAX) begin
                    to_cnt <= to_cnt + 1'b1;
                end
                if (to_hit) begin
                    scan_active <= 1'b0;
                    mask        <= '0;
                end
            end
        end
    end

`ifdef SEG7_SCAN_ERR_EN
    logic             multi_sel;
    logic             ms_evt;
    logic             bad_evt;
    logic             ms_done;
    logic             err_q;
    logic [CNT_W-1:0] ms_cnt;
    logic [7:0]       err_cnt;

    assign multi_sel = (n_low > ONE_LOW);
    assign ms_evt    = multi_sel && !pat_chg && !ms_done && (ms_cnt == STABLE_LAST);
    assign bad_evt   = cap && (dig_code == 4'hF);

    // ms_done keeps one long multi-select period from counting more than once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms_cnt  <= '0;
            ms_done <= 1'b0;
            err_q   <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (pat_chg) begin
                ms_cnt  <= '0;
                ms_done <= 1'b0;
            end else if (multi_sel && !ms_done) begin
                if (ms_cnt == STABLE_LAST) begin
                    ms_done <= 1'b1;
                end else begin
                    ms_cnt <= ms_cnt + 1'b1;
                end
            end
            if (ms_evt || bad_evt) begin
                err_q <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: frame table, directed corner sequences, random scan against a pin-level reference model.
module tb_seg7_scan_decoder;

    localparam int STABLE = 4;
    localparam int TMO    = 65535;
`ifdef SEG7_SCAN_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an_pin;
    logic [7:0]  cat_pin;
    logic [15:0] frame_data;
    logic [3:0]  frame_dp;
    logic        frame_valid;
    logic        scan_active;
    logic        err;

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .N_DIG(4), .STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .anodo(an_pin), .catodo(cat_pin),
        .frame_data(frame_data), .frame_dp(frame_dp), .frame_valid(frame_valid),
        .scan_active(scan_active), .err(err)
    );

    // Active-low a..g,dp drive codes for digits 0-9 with dp off.
    logic [7:0] seg_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int last_fv_cyc = 0;
    bit mcmp = 1'b0;

    typedef struct { int due; int dig; logic [3:0] code; logic dp; } cap_t;
    cap_t        pend[$];
    logic [11:0] run_val;
    int          run_len, run_start, since, to_edge, m_frames;
    logic [3:0]  m_stg [4];
    logic [3:0]  m_stg_dp, m_mask, m_dp;
    logic [15:0] m_data;
    logic        m_fv, m_act;

    typedef struct { logic [31:0] cats; logic [15:0] data; logic [3:0] dp; } frame_vec_t;
    frame_vec_t vec [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int low_count(input logic [3:0] a);
        return $countones(~a);
    endfunction

    function automatic logic [3:0] ref_decode(input logic [7:0] c);
        if (c[7:1] == 7'h7F) return 4'hA;
        for (int d = 0; d < 10; d++) begin
            if (seg_tab[d][7:1] == c[7:1]) return 4'(d);
        end
        return 4'hF;
    endfunction

    task automatic model_reset();
        run_val   = '1;
        run_len   = STABLE + 5;
        run_start = 0;
        pend.delete();
        for (int i = 0; i < 4; i++) m_stg[i] = 4'hA;
        m_stg_dp = '0;
        m_mask   = '0;
        m_data   = 16'hAAAA;
        m_dp     = '0;
        m_fv     = 1'b0;
        m_act    = 1'b0;
        since    = TMO;
        to_edge  = -100;
    endtask

    // A pin pattern sampled on STABLE+1 consecutive edges is captured two edges after the last of them.
    task automatic model_step();
        logic [11:0] p;
        cap_t c;
        p    = {an_pin, cat_pin};
        m_fv = 1'b0;
        if (p != run_val) begin
            run_val   = p;
            run_len   = 1;
            run_start = cyc;
        end else if (run_len < 1000) begin
            run_len++;
        end
        if (run_len == STABLE + 1 && low_count(p[11:8]) == 1 && to_edge < run_start + 2) begin
            c.due = cyc + 2;
            c.dig = 0;
            for (int i = 0; i < 4; i++) if (!p[8+i]) c.dig = i;
            c.code = ref_decode(p[7:0]);
            c.dp   = ~p[0];
            pend.push_back(c);
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            c = pend.pop_front();
            m_stg[c.dig]    = c.code;
            m_stg_dp[c.dig] = c.dp;
            m_mask[c.dig]   = 1'b1;
            since = 0;
            m_act = 1'b1;
            if (m_mask == 4'hF) begin
                for (int i = 0; i < 4; i++) m_data[4*i +: 4] = m_stg[i];
                m_dp   = m_stg_dp;
                m_fv   = 1'b1;
                m_mask = '0;
                m_frames++;
            end
        end else if (since < TMO) begin
            since++;
            if (since == TMO) begin
                m_act   = 1'b0;
                m_mask  = '0;
                to_edge = cyc;
                pend.delete();
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        if (frame_valid) begin
            fv_cnt++;
            last_fv_cyc = cyc;
        end
        if (mcmp)
            check("model", {10'd0, frame_valid, scan_active, frame_dp, frame_data},
                  {10'd0, m_fv, m_act, m_dp, m_data});
    endtask

    task automatic drive(input logic [3:0] a, input logic [7:0] c, input int n);
        an_pin  = a;
        cat_pin = c;
        repeat (n) cycle();
    endtask

    task automatic scan_frame(input logic [31:0] cats, input int hold);
        for (int d = 3; d >= 0; d--) drive(~(4'b0001 << d), cats[8*d +: 8], hold);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data"},  32'(frame_data),  32'h0000AAAA);
        check({tag, "_dp"},    32'(frame_dp),    32'h0);
        check({tag, "_valid"}, 32'(frame_valid), 32'h0);
        check({tag, "_active"},32'(scan_active), 32'h0);
        check({tag, "_err"},   32'(err),         32'h0);
    endtask

    initial begin
        int f0, mf0, c0, fall, hold;
        logic [3:0] a;
        logic [7:0] c;

        vec[0] = '{32'h0301251F, 16'h0827, 4'b0000};
        vec[1] = '{32'h9F090D99, 16'h1934, 4'b0000};
        vec[2] = '{32'h4940FF1E, 16'h56A7, 4'b0101};
        vec[3] = '{32'hFEFEFEFE, 16'hAAAA, 4'b1111};
        vec[4] = '{32'h01010101, 16'h8888, 4'b0000};
        vec[5] = '{32'h25994103, 16'h2460, 4'b0000};

        rst     = 1'b0;
        an_pin  = '1;
        cat_pin = '1;
        model_reset();
        m_frames = 0;
        #2;
        apply_reset();
        check_reset("rst0");

        for (int i = 0; i < 6; i++) begin
            f0 = fv_cnt;
            scan_frame(vec[i].cats, 20);
            check($sformatf("tbl%0d_frames", i), 32'(fv_cnt - f0), 32'd1);
            check($sformatf("tbl%0d_data", i),   32'(frame_data),  32'(vec[i].data));
            check($sformatf("tbl%0d_dp", i),     32'(frame_dp),    32'(vec[i].dp));
            check($sformatf("tbl%0d_active", i), 32'(scan_active), 32'd1);
        end
        check("err_clean", 32'(err), 32'd0);

        // 3-cycle "8" on digit 1 is too short to be captured.
        f0 = fv_cnt;
        drive(4'b0111, 8'h03, 20);
        drive(4'b1011, 8'h01, 20);
        drive(4'b1101, 8'h01, 3);
        drive(4'b1101, 8'h25, 20);
        drive(4'b1110, 8'h1F, 20);
        check("glitch_frames", 32'(fv_cnt - f0), 32'd1);
        check("glitch_data",   32'(frame_data),  32'h0827);

        f0   = fv_cnt;
        c0   = last_fv_cyc;
        fall = -1;
        an_pin  = 4'hF;
        cat_pin = 8'hFF;
        for (int i = 0; i < TMO + 50 && fall < 0; i++) begin
            cycle();
            if (!scan_active) fall = cyc;
        end
        check("timeout_gap",    32'(fall - c0),    32'(TMO));
        check("timeout_hold",   32'(frame_data),   32'h0827);
        check("timeout_frames", 32'(fv_cnt - f0),  32'd0);

        f0 = fv_cnt;
        drive(4'b0111, 8'h9F, 20);
        drive(4'b1011, 8'h25, 20);
        drive(4'b1100, 8'h0D, 10);
        check("multi_noframe", 32'(fv_cnt - f0), 32'd0);
        drive(4'b1101, 8'h0D, 20);
        drive(4'b1110, 8'h99, 20);
        check("multi_frames", 32'(fv_cnt - f0), 32'd1);
        check("multi_data",   32'(frame_data),  32'h1234);
        check("multi_active", 32'(scan_active), 32'd1);
        check("multi_err",    32'(err),         32'(ERR_EXP));

        apply_reset();
        check_reset("rst1");
        scan_frame(32'h0301551F, 20);
        check("inval_data", 32'(frame_data), 32'h08F7);
        check("inval_err",  32'(err),        32'(ERR_EXP));

        apply_reset();
        f0 = fv_cnt;
        drive(4'b1110, 8'h49, 20);
        drive(4'b1101, 8'h03, 20);
        drive(4'b1011, 8'h9F, 10);
        apply_reset();
        check_reset("rst_mid");
        check("partial_noframe", 32'(fv_cnt - f0), 32'd0);
        scan_frame(32'h039F0349, 20);
        check("after_rst_frames", 32'(fv_cnt - f0), 32'd1);
        check("after_rst_data",   32'(frame_data),  32'h0105);

        apply_reset();
        mf0  = m_frames;
        f0   = fv_cnt;
        mcmp = 1'b1;
        for (int s = 0; s < 400; s++) begin
            case ($urandom_range(0, 9))
                0: a = 4'hF;
                1: begin
                    a = 4'($urandom_range(0, 15));
                    if (low_count(a) < 2) a = 4'b0101;
                end
                default: a = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 4) == 0) begin
                c = 8'($urandom);
            end else begin
                c = seg_tab[$urandom_range(0, 9)];
                if ($urandom_range(0, 1) == 1) c[0] = 1'b0;
            end
            hold = $urandom_range(1, 10);
            drive(a, c, hold);
        end
        drive(4'hF, 8'hFF, 10);
        mcmp = 1'b0;
        check("rand_frames", 32'(fv_cnt - f0), 32'(m_frames - mf0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
